snn_layer_controller: RTL and testbench

SNN_LAYER_CONTROLLER -- requirements
Module: snn_layer_controller

---
 rtl/snn_layer_controller.sv | 178 +++++++++++++++++
 tb/tb_snn_layer_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_layer_controller.sv
`default_nettype none
// ============================================================================
//  Module      : snn_layer_controller
//  Description : Sequencer for one spiking-neural-network layer. Each accepted
//                input event sweeps all neurons twice (weight/potential load,
//                then potential write-back) around a one-cycle accumulate.
//                Every PERIOD cycles a spike phase runs: spike_done pulses and
//                repeats while the datapath still reports firing neurons.
//  Options     : define SNN_LEAK_EN to add a LEAK sweep after each spike phase
//                (default build: no LEAK state, leak_en tied low).
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_layer_controller #(
    parameter int N_NEURONS = 16,
    parameter int N_INPUTS  = 16,
    parameter int PERIOD    = 64,
    parameter int NA        = $clog2(N_NEURONS),
    parameter int IA        = $clog2(N_INPUTS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 event_valid,
    input  logic [IA-1:0]        event_addr,
    output logic                 event_ready,
    input  logic [N_NEURONS-1:0] spike,
    output logic                 weight_w_en,
    output logic                 memb_pot_w_en,
    output logic                 accum_en,
    output logic                 memb_pot_mem_w_en,
    output logic                 leak_en,
    output logic                 spike_done,
    output logic [IA+NA-1:0]     mem_addr,
    output logic [NA-1:0]        neuron_idx,
    output logic                 busy
);

    localparam int            PW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);
    localparam logic [NA-1:0] NMAX = NA'(N_NEURONS - 1);

`ifdef SNN_LEAK_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ACCUM   = 3'd2,
        S_STORE   = 3'd3,
        S_SPIKE   = 3'd4,
        S_CLEANUP = 3'd5,
        S_LEAK    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ACCUM   = 3'd2,
        S_STORE   = 3'd3,
        S_SPIKE   = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [PW-1:0]  pcnt_q,  pcnt_d;     // cycles since last spike phase
    logic [NA-1:0]  nidx_q,  nidx_d;     // neuron sweep counter
    logic [IA-1:0]  addr_q,  addr_d;     // address of the event in progress
    logic [NA-1:0]  rent_q,  rent_d;     // spike re-entries in this phase

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            nidx_q  <= '0;
            addr_q  <= '0;
            rent_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            nidx_q  <= nidx_d;
            addr_q  <= addr_d;
            rent_q  <= rent_d;
        end
    end

    // Next-state and counter logic; the spike phase wins over a new event
    always_comb begin
        state_d = state_q;
        nidx_d  = nidx_q;
        addr_d  = addr_q;
        rent_d  = rent_q;
        // Saturate so a long event sequence only defers the spike phase
        pcnt_d  = (pcnt_q == PMAX) ? pcnt_q : pcnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                rent_d = '0;
                nidx_d = '0;
                if (pcnt_q == PMAX) begin
                    state_d = S_SPIKE;
                end else if (event_valid) begin
                    addr_d  = event_addr;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (nidx_q == NMAX) begin
                    nidx_d  = '0;
                    state_d = S_ACCUM;
                end else begin
                    nidx_d = nidx_q + 1'b1;
                end
            end
            S_ACCUM: begin
                state_d = S_STORE;
            end
            S_STORE: begin
                if (nidx_q == NMAX) begin
                    nidx_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    nidx_d = nidx_q + 1'b1;
                end
            end
            S_SPIKE: begin
                pcnt_d  = '0;
                state_d = S_CLEANUP;
            end
            S_CLEANUP: begin
                // At most N_NEURONS spike_done pulses in one phase
                if ((spike != '0) && (rent_q != NMAX)) begin
                    rent_d  = rent_q + 1'b1;
                    state_d = S_SPIKE;
                end else begin
                    nidx_d  = '0;
`ifdef SNN_LEAK_EN
                    state_d = S_LEAK;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef SNN_LEAK_EN
            S_LEAK: begin
                if (nidx_q == NMAX) begin
                    nidx_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    nidx_d = nidx_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                nidx_d  = '0;
            end
        endcase
    end

    // Output decode from state and counters only
    assign busy              = (state_q != S_IDLE);
    // Held low during reset so every output reads zero while reset_n is low
    assign event_ready       = reset_n && (state_q == S_IDLE) && (pcnt_q != PMAX);
    assign weight_w_en       = (state_q == S_LOAD);
    assign memb_pot_w_en     = (state_q == S_LOAD);
    assign accum_en          = (state_q == S_ACCUM);
    assign memb_pot_mem_w_en = (state_q == S_STORE);
    assign spike_done        = (state_q == S_SPIKE);
    assign neuron_idx        = nidx_q;
    assign mem_addr          = {addr_q, nidx_q};

`ifdef SNN_LEAK_EN
    assign leak_en = (state_q == S_LEAK);
`else
    assign leak_en = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_layer_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_layer_controller
//  Description : Directed self-checking bench for snn_layer_controller with
//                default parameters (16 neurons, 16 inputs, PERIOD 64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_layer_controller;

    localparam int NN = 16;

    logic          clock;
    logic          reset_n;
    logic          event_valid;
    logic [3:0]    event_addr;
    logic          event_ready;
    logic [NN-1:0] spike;
    logic          weight_w_en;
    logic          memb_pot_w_en;
    logic          accum_en;
    logic          memb_pot_mem_w_en;
    logic          leak_en;
    logic          spike_done;
    logic [7:0]    mem_addr;
    logic [3:0]    neuron_idx;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    snn_layer_controller dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .event_valid       (event_valid),
        .event_addr        (event_addr),
        .event_ready       (event_ready),
        .spike             (spike),
        .weight_w_en       (weight_w_en),
        .memb_pot_w_en     (memb_pot_w_en),
        .accum_en          (accum_en),
        .memb_pot_mem_w_en (memb_pot_mem_w_en),
        .leak_en           (leak_en),
        .spike_done        (spike_done),
        .mem_addr          (mem_addr),
        .neuron_idx        (neuron_idx),
        .busy              (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int n_en();
        return $countones({weight_w_en | memb_pot_w_en, accum_en, memb_pot_mem_w_en, leak_en});
    endfunction

    initial begin
        int busy_n;
        int waits;
        int t0;
        int pulses;
        int p_first;
        int p_second;
        int leak_n;
        int early_load;

        reset_n     = 1'b0;
        event_valid = 1'b0;
        event_addr  = '0;
        spike       = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy",   busy, 0);
        check("rst_ready",  event_ready, 0);
        check("rst_idx",    neuron_idx, 0);
        check("rst_addr",   mem_addr, 0);
        check("rst_sdone",  spike_done, 0);

        // Release: period counter reads 0 in this cycle
        reset_n = 1'b1;
        #1;
        check("rel_ready", event_ready, 1);

        // ---------------- event 5: full load/accum/store ----------------
        event_valid = 1'b1;
        event_addr  = 4'd5;
        tick();
        event_valid = 1'b0;
        event_addr  = 4'd0;
        busy_n = 0;
        for (int i = 0; i < NN; i++) begin
            check("load_wen",  weight_w_en, 1);
            check("load_pen",  memb_pot_w_en, 1);
            check("load_addr", mem_addr, 8'h50 + i);
            check("load_excl", n_en(), 1);
            busy_n += busy;
            tick();
        end
        check("accum_en",   accum_en, 1);
        check("accum_excl", n_en(), 1);
        busy_n += busy;
        tick();
        for (int i = 0; i < NN; i++) begin
            check("store_wen", memb_pot_mem_w_en, 1);
            check("store_idx", neuron_idx, i);
            check("store_excl", n_en(), 1);
            busy_n += busy;
            tick();
        end
        // LOAD+ACCUM+STORE occupy 33 cycles; accept-to-accept is 34
        check("busy_cycles", busy_n, 2 * NN + 1);
        check("idle_busy",  busy, 0);
        check("idle_ready", event_ready, 1);

        // ---------------- back-to-back event 3 at minimum spacing ----------------
        event_valid = 1'b1;
        event_addr  = 4'd3;
        tick();
        event_valid = 1'b0;
        check("ev2_addr0", mem_addr, 8'h30);
        check("ev2_busy",  busy, 1);
        // Counter saturates during this event; spike phase must wait for IDLE
        repeat (2 * NN + 1) tick();
        check("defer_busy",  busy, 0);
        check("defer_ready", event_ready, 0);

        // ---------------- event held while counter at 63 ----------------
        event_valid = 1'b1;
        event_addr  = 4'd9;
        tick();
        check("prio_sdone", spike_done, 1);
        check("prio_load",  weight_w_en, 0);
        waits = 0;
        early_load = 0;
        while (!event_ready && waits < 60) begin
            tick();
            waits++;
            early_load += weight_w_en;
        end
`ifdef SNN_LEAK_EN
        check("prio_wait", waits, 2 + NN);
`else
        check("prio_wait", waits, 2);
`endif
        check("prio_noload", early_load, 0);
        tick();
        event_valid = 1'b0;
        event_addr  = 4'd0;
        check("ev3_addr0", mem_addr, 8'h90);
        repeat (7) tick();
        check("ev3_idx7",  neuron_idx, 7);
        check("ev3_addr7", mem_addr, 8'h97);

        // ---------------- reset in the middle of LOAD ----------------
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wen",  weight_w_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_idx",  neuron_idx, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_rdy",  event_ready, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_rdy",  event_ready, 1);
        check("post_rst_idx",  neuron_idx, 0);

        // ---------------- free-running spike period ----------------
        pulses   = 0;
        p_first  = -1;
        p_second = -1;
        leak_n   = 0;
        for (int t = 1; t <= 150; t++) begin
            tick();
            if (spike_done) begin
                pulses++;
                if (p_first < 0) p_first = t;
                else if (p_second < 0) p_second = t;
            end
            if (t == 62) check("ready_62", event_ready, 1);
            if (t == 63) check("ready_63", event_ready, 0);
            if (leak_en) begin
                check("leak_idx",  neuron_idx, leak_n % NN);
                check("leak_busy", busy, 1);
                leak_n++;
            end
        end
        check("per_pulses", pulses, 2);
        check("per_first",  p_first, 64);
        check("per_gap",    p_second - p_first, 65);
`ifdef SNN_LEAK_EN
        check("leak_cycles", leak_n, 2 * NN);
`else
        check("leak_cycles", leak_n, 0);
`endif

        // ---------------- spike re-entry: two nonzero visits ----------------
        waits = 0;
        while (!spike_done && waits < 100) begin
            tick();
            waits++;
        end
        check("phase3_seen", spike_done, 1);
        spike  = 16'h0001;
        pulses = 1;
        t0 = 0;
        while (busy && t0 < 100) begin
            tick();
            t0++;
            if (spike_done) begin
                pulses++;
                if (pulses >= 3) spike = '0;
            end
        end
        check("reent_pulses", pulses, 3);
        check("reent_idle",   busy, 0);

        // ---------------- spike held nonzero: capped pulses ----------------
        spike = 16'hFFFF;
        waits = 0;
        while (!spike_done && waits < 100) begin
            tick();
            waits++;
        end
        check("cap_seen", spike_done, 1);
        pulses = 1;
        t0 = 0;
        while (busy && t0 < 200) begin
            tick();
            t0++;
            pulses += spike_done;
        end
        check("cap_pulses", pulses, NN);
        check("cap_idle",   busy, 0);
        spike = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
